// File: rtl/cdc_gray_pkg.sv
// Shared types and Gray-code helpers for the Gray counter CDC receiver.
// Helpers work on a fixed 64-bit word; narrower counters are zero-extended.
package cdc_gray_pkg;

   localparam int GRAY_MAX_W = 64;

   typedef logic [GRAY_MAX_W-1:0] gray_word_t;

   typedef enum logic [1:0] {FILL, LOAD, RUN} gray_sync_state_e;

   // Fill counter must reach STAGES, so it needs room for STAGES+1 codes.
   function automatic int fill_cnt_w(input int stages);
      return $clog2(stages + 1);
   endfunction

   function automatic gray_word_t bin2gray(input gray_word_t b);
      return b ^ (b >> 1);
   endfunction

   // Zero-extension commutes with decode: the high bits stay zero.
   function automatic gray_word_t gray2bin(input gray_word_t g);
      gray_word_t b;
      b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
      for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   function automatic logic onehot_or_zero(input gray_word_t v);
      return (v & (v - gray_word_t'(1))) == '0;
   endfunction

endpackage

// File: rtl/cdc_gray_sync_ch.sv
// One channel: flop-chain synchroniser, fill/load/run sequencing, Gray-step
// validity check, saturating error counter; dir check under CDC_GRAY_DIR_CHECK_EN.
module cdc_gray_sync_ch
   import cdc_gray_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int STAGES    = 2,
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [WIDTH-1:0]     gray_in,
   input  logic                 err_clr,
   output logic [WIDTH-1:0]     bin_out,
   output logic                 out_valid,
   output logic                 upd,
   output logic                 gray_err,
   output logic [ERR_CNT_W-1:0] err_cnt,
   output logic                 dir_err
);

   localparam int FW = fill_cnt_w(STAGES);
   localparam logic [FW-1:0] FILL_LAST = FW'(STAGES - 1);
   localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

   logic [STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
   gray_sync_state_e             state_q, state_d;
   logic [FW-1:0]                fill_q, fill_d;
   logic [WIDTH-1:0]             ref_q, ref_d;
   logic [WIDTH-1:0]             bin_q, bin_d;
   logic                         valid_q, valid_d;
   logic                         upd_q, upd_d;
   logic                         gerr_q, gerr_d;
   logic [ERR_CNT_W-1:0]         cnt_q, cnt_d;
   logic [WIDTH-1:0]             s, delta, s_bin;
   logic                         reject;

   always_comb begin
      sync_d    = sync_q;
      sync_d[0] = gray_in;
      for (int i = 1; i < STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
   end

   assign s     = sync_q[STAGES-1];
   assign delta = s ^ ref_q;
   assign s_bin = WIDTH'(gray2bin(gray_word_t'(s)));

   always_comb begin
      state_d = state_q;
      fill_d  = fill_q;
      ref_d   = ref_q;
      bin_d   = bin_q;
      valid_d = valid_q;
      upd_d   = 1'b0;
      gerr_d  = 1'b0;
      reject  = 1'b0;
      case (state_q)
         FILL: begin
            fill_d = fill_q + 1'b1;
            if (fill_q == FILL_LAST) state_d = LOAD;
         end
         LOAD: begin
            ref_d   = s;
            bin_d   = s_bin;
            valid_d = 1'b1;
            state_d = RUN;
         end
         RUN: begin
            // ref follows s even on rejection so a real jump costs one sample
            ref_d = s;
            if (delta != '0) begin
               if (onehot_or_zero(gray_word_t'(delta))) begin
                  bin_d = s_bin;
                  upd_d = 1'b1;
               end else begin
                  reject = 1'b1;
                  gerr_d = 1'b1;
               end
            end
         end
         default: state_d = FILL;
      endcase
   end

   always_comb begin
      cnt_d = cnt_q;
      if (err_clr)
         cnt_d = reject ? ERR_CNT_W'(1) : '0;
      else if (reject && cnt_q != ERR_MAX)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '0;
         state_q <= FILL;
         fill_q  <= '0;
         ref_q   <= '0;
         bin_q   <= '0;
         valid_q <= 1'b0;
         upd_q   <= 1'b0;
         gerr_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync_q  <= sync_d;
         state_q <= state_d;
         fill_q  <= fill_d;
         ref_q   <= ref_d;
         bin_q   <= bin_d;
         valid_q <= valid_d;
         upd_q   <= upd_d;
         gerr_q  <= gerr_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef CDC_GRAY_DIR_CHECK_EN
   logic dir_q, dir_d;

   always_comb begin
      dir_d = 1'b0;
      if (state_q == RUN && upd_d) dir_d = (s_bin != bin_q + 1'b1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) dir_q <= 1'b0;
      else        dir_q <= dir_d;
   end

   assign dir_err = dir_q;
`else
   assign dir_err = 1'b0;
`endif

   assign bin_out   = bin_q;
   assign out_valid = valid_q;
   assign upd       = upd_q;
   assign gray_err  = gerr_q;
   assign err_cnt   = cnt_q;

endmodule

// File: rtl/cdc_gray_sync_decoder.sv
// Multi-channel Gray counter CDC receiver; one cdc_gray_sync_ch per channel.
// Optional direction check enabled by defining CDC_GRAY_DIR_CHECK_EN.
module cdc_gray_sync_decoder
   import cdc_gray_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int STAGES    = 2,
   parameter int NUM_CH    = 1,
   parameter int ERR_CNT_W = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_CH*WIDTH-1:0]     gray_in,
   input  logic                        err_clr,
   output logic [NUM_CH*WIDTH-1:0]     bin_out,
   output logic [NUM_CH-1:0]           out_valid,
   output logic [NUM_CH-1:0]           upd,
   output logic [NUM_CH-1:0]           gray_err,
   output logic [NUM_CH*ERR_CNT_W-1:0] err_cnt,
   output logic [NUM_CH-1:0]           dir_err
);

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      cdc_gray_sync_ch #(
         .WIDTH     (WIDTH),
         .STAGES    (STAGES),
         .ERR_CNT_W (ERR_CNT_W)
      ) u_ch (
         .clk       (clk),
         .rst_n     (rst_n),
         .gray_in   (gray_in[c*WIDTH +: WIDTH]),
         .err_clr   (err_clr),
         .bin_out   (bin_out[c*WIDTH +: WIDTH]),
         .out_valid (out_valid[c]),
         .upd       (upd[c]),
         .gray_err  (gray_err[c]),
         .err_cnt   (err_cnt[c*ERR_CNT_W +: ERR_CNT_W]),
         .dir_err   (dir_err[c])
      );
   end

endmodule
